mmio_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the single data-memory / memory-mapped I/O port. It shares the port between the CPU load/store unit and a debug loader. Each requester issues one word access at a time. The block serialises accesses round-robin, routes writes to `HEX_ADDR` into the hex-display register and all other addresses to data memory, and returns read data after the memory's fixed read latency.

---
 rtl/mmio_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_mmio_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_arbiter.sv
//------------------------------------------------------------------------------
// Module      : mmio_arbiter
// Description : Round-robin arbiter and access sequencer that shares one
//               data-memory / memory-mapped I/O port between the CPU
//               load/store unit and a debug loader. Writes to HEX_ADDR land
//               in the hex-display register; every other address goes to
//               data memory. Reads return after the memory's fixed latency.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module mmio_arbiter #(
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] HEX_ADDR = 10'h3FF,
    parameter int                RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,

    // CPU load/store requester
    input  logic              cpu_req,
    input  logic              cpu_wr_ena,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,

    // Debug loader requester
    input  logic              dbg_req,
    input  logic              dbg_wr_ena,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_done,
    output logic [DATA_W-1:0] dbg_rdata,

    // Shared data-memory port
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_ena,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,

    // Hex-display register
    output logic [DATA_W-1:0] hex_display
);

    // Wait counter only ever holds RD_LAT-1, i.e. 0..3.
    localparam int CNT_W = 2;

    // Owner / priority-pointer encoding.
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    // An out-of-range latency would overflow the wait counter.
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_rd_lat_range
        $error("mmio_arbiter: RD_LAT must be in 1..4");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_ptr;       // port that wins when both request
    logic                r_owner;     // port owning the current transaction
    logic                r_wr;        // latched write enable
    logic [ADDR_W-1:0]   r_addr;      // latched address
    logic [DATA_W-1:0]   r_wdata;     // latched write data
    logic [CNT_W-1:0]    r_cnt;       // remaining read-latency cycles

    logic                r_cpu_gnt;
    logic                r_dbg_gnt;
    logic                r_cpu_done;
    logic                r_dbg_done;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_dbg_rdata;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_wr_ena;
    logic [DATA_W-1:0]   r_mem_wr_data;
    logic [DATA_W-1:0]   r_hex;

    // Arbitration: a lone requester wins, otherwise the pointer decides.
    logic                w_any_req;
    logic                w_pick_dbg;
    logic                w_win_wr;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_wdata;
    logic                w_win_hex;
    logic                w_win_mem_wr;

    assign w_any_req    = cpu_req | dbg_req;
    assign w_pick_dbg   = dbg_req & (~cpu_req | (r_ptr == OWN_DBG));
    assign w_win_wr     = w_pick_dbg ? dbg_wr_ena : cpu_wr_ena;
    assign w_win_addr   = w_pick_dbg ? dbg_addr   : cpu_addr;
    assign w_win_wdata  = w_pick_dbg ? dbg_wdata  : cpu_wdata;
    assign w_win_hex    = (w_win_addr == HEX_ADDR);
    assign w_win_mem_wr = w_win_wr & ~w_win_hex;

    // Decode of the latched transaction.
    logic                w_lat_hex;
    logic                w_enter_done;
    logic                w_capture;
    logic [DATA_W-1:0]   w_cap_val;

    assign w_lat_hex    = (r_addr == HEX_ADDR);
    // ACCESS finishes writes and hex reads; WAIT finishes memory reads.
    assign w_enter_done = ((r_state == S_ACCESS) && (r_wr || w_lat_hex)) ||
                          ((r_state == S_WAIT)   && (r_cnt == '0));
    assign w_capture    = w_enter_done & ~r_wr;
    // Hex reads return the display register; memory reads the memory bus.
    assign w_cap_val    = (r_state == S_ACCESS) ? r_hex : mem_rd_data;

    // Sequencer FSM with registered grant, done and memory-port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ptr         <= OWN_CPU;
            r_owner       <= OWN_CPU;
            r_wr          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_cnt         <= '0;
            r_cpu_gnt     <= 1'b0;
            r_dbg_gnt     <= 1'b0;
            r_cpu_done    <= 1'b0;
            r_dbg_done    <= 1'b0;
            r_cpu_rdata   <= '0;
            r_dbg_rdata   <= '0;
            r_mem_addr    <= '0;
            r_mem_wr_ena  <= 1'b0;
            r_mem_wr_data <= '0;
            r_hex         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner       <= w_pick_dbg;
                        r_wr          <= w_win_wr;
                        r_addr        <= w_win_addr;
                        r_wdata       <= w_win_wdata;
                        r_cpu_gnt     <= ~w_pick_dbg;
                        r_dbg_gnt     <= w_pick_dbg;
                        // Hex accesses are kept off the memory bus entirely.
                        r_mem_addr    <= w_win_hex ? '0 : w_win_addr;
                        r_mem_wr_ena  <= w_win_mem_wr;
                        r_mem_wr_data <= w_win_mem_wr ? w_win_wdata : '0;
                        r_state       <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    if (r_wr) begin
                        if (w_lat_hex) begin
                            r_hex <= r_wdata;
                        end
                        r_state <= S_DONE;
                    end else if (w_lat_hex) begin
                        r_state <= S_DONE;
                    end else begin
                        // RD_LAT==1 still passes through one WAIT cycle at
                        // count 0, which is where the data is captured.
                        r_cnt   <= CNT_W'(RD_LAT - 1);
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_DONE: begin
                    r_cpu_done <= 1'b0;
                    r_dbg_done <= 1'b0;
                    r_cpu_gnt  <= 1'b0;
                    r_dbg_gnt  <= 1'b0;
                    r_state    <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Common work on the edge that enters DONE: pulse done, hand
            // priority to the other port, release the memory bus.
            if (w_enter_done) begin
                r_cpu_done    <= (r_owner == OWN_CPU);
                r_dbg_done    <= (r_owner == OWN_DBG);
                r_ptr         <= ~r_owner;
                r_mem_addr    <= '0;
                r_mem_wr_ena  <= 1'b0;
                r_mem_wr_data <= '0;
            end

            // Read data lands only in the owner's register; the other holds.
            if (w_capture) begin
                if (r_owner == OWN_DBG) begin
                    r_dbg_rdata <= w_cap_val;
                end else begin
                    r_cpu_rdata <= w_cap_val;
                end
            end
        end
    end

    assign cpu_gnt     = r_cpu_gnt;
    assign dbg_gnt     = r_dbg_gnt;
    assign cpu_done    = r_cpu_done;
    assign dbg_done    = r_dbg_done;
    assign cpu_rdata   = r_cpu_rdata;
    assign dbg_rdata   = r_dbg_rdata;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_ena  = r_mem_wr_ena;
    assign mem_wr_data = r_mem_wr_data;
    assign hex_display = r_hex;

endmodule

`default_nettype wire

// File: tb/tb_mmio_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_mmio_arbiter
// Description : Self-checking bench for mmio_arbiter: a table of single
//               accesses plus hand-written reset, round-robin and contention
//               sequences, against a latency-accurate memory model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mmio_arbiter;

    localparam int          ADDR_W = 10;
    localparam int          DATA_W = 32;
    localparam int          RD_LAT = 2;
    localparam logic [9:0]  HEX    = 10'h3FF;
    localparam int          RD_CYC = 2 + RD_LAT;   // IDLE-to-done for memory reads

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_wr_ena, dbg_req, dbg_wr_ena;
    logic [ADDR_W-1:0] cpu_addr, dbg_addr, mem_addr;
    logic [DATA_W-1:0] cpu_wdata, dbg_wdata, mem_wr_data, mem_rd_data;
    logic              cpu_gnt, cpu_done, dbg_gnt, dbg_done, mem_wr_ena;
    logic [DATA_W-1:0] cpu_rdata, dbg_rdata, hex_display;

    int n_checks = 0;
    int n_fail   = 0;
    int overlap  = 0;

    mmio_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .HEX_ADDR (HEX),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_wr_ena  (cpu_wr_ena),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_done    (cpu_done),
        .cpu_rdata   (cpu_rdata),
        .dbg_req     (dbg_req),
        .dbg_wr_ena  (dbg_wr_ena),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_gnt     (dbg_gnt),
        .dbg_done    (dbg_done),
        .dbg_rdata   (dbg_rdata),
        .mem_addr    (mem_addr),
        .mem_wr_ena  (mem_wr_ena),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .hex_display (hex_display)
    );

    always #5 clk = ~clk;

    // Memory model: data for the address cycle appears RD_LAT cycles later.
    logic [DATA_W-1:0] mem  [0:1023];
    logic [DATA_W-1:0] pipe [0:RD_LAT-1];

    always @(posedge clk) begin
        if (mem_wr_ena) mem[mem_addr] <= mem_wr_data;
        pipe[0] <= mem[mem_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rd_data = pipe[RD_LAT-1];

    // Both grants high together is never legal.
    always @(negedge clk) if (cpu_gnt && dbg_gnt) overlap++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        is_dbg;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        int          lat;        // cycles from the IDLE cycle T to done
        logic [31:0] exp_cpu;    // cpu_rdata at done
        logic [31:0] exp_dbg;    // dbg_rdata at done
        logic [31:0] exp_hex;    // hex_display at done
        int          exp_wrcnt;  // cycles with mem_wr_ena high
    } vec_t;

    vec_t vecs [8];

    // One complete access from an idle port, with per-cycle bus checks.
    task automatic do_access(input int idx, input vec_t v);
        int n = 0, wrcnt = 0, bus_bad = 0, gnt_bad = 0;
        logic fin = 1'b0, mydone, mygnt, othgnt, is_mem;
        is_mem = (v.addr != HEX);
        if (v.is_dbg) begin
            dbg_wr_ena = v.wr; dbg_addr = v.addr; dbg_wdata = v.wdata; dbg_req = 1'b1;
        end else begin
            cpu_wr_ena = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_req = 1'b1;
        end
        while (!fin && n < 20) begin
            tick();
            n++;
            mydone = v.is_dbg ? dbg_done : cpu_done;
            mygnt  = v.is_dbg ? dbg_gnt  : cpu_gnt;
            othgnt = v.is_dbg ? cpu_gnt  : dbg_gnt;
            if (mem_wr_ena) wrcnt++;
            if (!mygnt || othgnt) gnt_bad++;
            if (mydone) begin
                if (mem_addr !== '0 || mem_wr_ena !== 1'b0 || mem_wr_data !== '0) bus_bad++;
            end else if (is_mem) begin
                if (mem_addr !== v.addr) bus_bad++;
                if (v.wr && mem_wr_data !== v.wdata) bus_bad++;
            end
            fin = mydone;
        end
        check($sformatf("v%0d_latency", idx), n, v.lat);
        check($sformatf("v%0d_cpu_rdata", idx), cpu_rdata, v.exp_cpu);
        check($sformatf("v%0d_dbg_rdata", idx), dbg_rdata, v.exp_dbg);
        check($sformatf("v%0d_hex", idx), hex_display, v.exp_hex);
        check($sformatf("v%0d_mem_wr_cycles", idx), wrcnt, v.exp_wrcnt);
        check($sformatf("v%0d_mem_bus", idx), bus_bad, 0);
        check($sformatf("v%0d_grant", idx), gnt_bad, 0);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        tick();
        check($sformatf("v%0d_idle_after", idx), {cpu_gnt, dbg_gnt, cpu_done, dbg_done}, 0);
    endtask

    initial begin
        int k, seq[4], aborted_done, cyc, cpu_done_c, dbg_gnt_c, dbg_done_c;
        logic prev_c, prev_d, fin;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h5A5A_0000 | 32'(i);
        mem[4] = 32'hA5A5_0001;
        for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;

        //          dbg   wr    addr     wdata          lat     cpu_rd         dbg_rd         hex            wr
        vecs[0] = '{1'b0, 1'b1, 10'h3FF, 32'hDEADBEEF,  2,      32'h0,         32'h0,         32'hDEADBEEF,  0};
        vecs[1] = '{1'b0, 1'b0, 10'h3FF, 32'h0,         2,      32'hDEADBEEF,  32'h0,         32'hDEADBEEF,  0};
        vecs[2] = '{1'b1, 1'b1, 10'h010, 32'h12345678,  2,      32'hDEADBEEF,  32'h0,         32'hDEADBEEF,  1};
        vecs[3] = '{1'b0, 1'b0, 10'h004, 32'h0,         RD_CYC, 32'hA5A50001,  32'h0,         32'hDEADBEEF,  0};
        vecs[4] = '{1'b1, 1'b0, 10'h010, 32'h0,         RD_CYC, 32'hA5A50001,  32'h12345678,  32'hDEADBEEF,  0};
        vecs[5] = '{1'b1, 1'b1, 10'h3FF, 32'h0000CAFE,  2,      32'hA5A50001,  32'h12345678,  32'h0000CAFE,  0};
        vecs[6] = '{1'b1, 1'b0, 10'h3FF, 32'h0,         2,      32'hA5A50001,  32'h0000CAFE,  32'h0000CAFE,  0};
        vecs[7] = '{1'b0, 1'b0, 10'h3FE, 32'h0,         RD_CYC, 32'h5A5A03FE,  32'h0000CAFE,  32'h0000CAFE,  0};

        reset = 1'b1;
        cpu_req = 1'b0; cpu_wr_ena = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_wr_ena = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        tick();
        tick();
        check("rst_gnt_done", {cpu_gnt, dbg_gnt, cpu_done, dbg_done}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wr", {mem_wr_ena, mem_wr_data}, 0);
        check("rst_hex", hex_display, 0);
        check("rst_rdata", cpu_rdata | dbg_rdata, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) do_access(i, vecs[i]);

        // Reset lands in the middle of a dbg memory read's WAIT phase.
        dbg_wr_ena = 1'b0; dbg_addr = 10'h004; dbg_req = 1'b1;
        tick();                       // ACCESS
        tick();                       // first WAIT cycle
        check("abort_pre_gnt", dbg_gnt, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_gnt_done", {cpu_gnt, dbg_gnt, cpu_done, dbg_done}, 0);
        check("abort_mem", {mem_wr_ena, mem_addr, mem_wr_data}, 0);
        check("abort_hex", hex_display, 0);
        check("abort_cpu_rdata", cpu_rdata, 0);
        check("abort_dbg_rdata", dbg_rdata, 0);
        dbg_req = 1'b0;
        aborted_done = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dbg_done) aborted_done++;
        end
        check("abort_no_done", aborted_done, 0);

        // Release with both requesting hex reads: cpu first, then alternate.
        reset = 1'b0;
        cpu_wr_ena = 1'b0; cpu_addr = HEX;
        dbg_wr_ena = 1'b0; dbg_addr = HEX;
        cpu_req = 1'b1; dbg_req = 1'b1;
        k = 0; prev_c = 1'b0; prev_d = 1'b0; fin = 1'b0; cyc = 0;
        for (int i = 0; i < 4; i++) seq[i] = -1;
        while (!fin && cyc < 60) begin
            tick();
            cyc++;
            if (cpu_gnt && !prev_c && k < 4) begin seq[k] = 0; k++; end
            if (dbg_gnt && !prev_d && k < 4) begin seq[k] = 1; k++; end
            prev_c = cpu_gnt;
            prev_d = dbg_gnt;
            if (k >= 4) begin
                cpu_req = 1'b0;
                dbg_req = 1'b0;
                fin = cpu_done | dbg_done;
            end else begin
                cpu_req = ~cpu_done;
                dbg_req = ~dbg_done;
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        check("rr_completed", fin, 1);
        check("rr_grant0_cpu", seq[0], 0);
        check("rr_grant1_dbg", seq[1], 1);
        check("rr_grant2_cpu", seq[2], 0);
        check("rr_grant3_dbg", seq[3], 1);
        tick();

        // dbg raises its request during a cpu ACCESS and must wait for IDLE.
        cpu_wr_ena = 1'b1; cpu_addr = 10'h020; cpu_wdata = 32'h0BADF00D; cpu_req = 1'b1;
        dbg_wr_ena = 1'b1; dbg_addr = HEX;     dbg_wdata = 32'h0000BEEF;
        cpu_done_c = -1; dbg_gnt_c = -1; dbg_done_c = -1; cyc = 0;
        while (dbg_done_c < 0 && cyc < 20) begin
            tick();
            cyc++;
            if (cyc == 1) dbg_req = 1'b1;
            if (cpu_done && cpu_done_c < 0) begin cpu_done_c = cyc; cpu_req = 1'b0; end
            if (dbg_gnt && dbg_gnt_c < 0) dbg_gnt_c = cyc;
            if (dbg_done) begin
                dbg_done_c = cyc;
                dbg_req = 1'b0;
                check("cont_hex", hex_display, 32'h0000BEEF);
            end
        end
        check("cont_cpu_done_cycle", cpu_done_c, 2);
        check("cont_dbg_gnt_cycle", dbg_gnt_c, 4);
        check("cont_dbg_done_cycle", dbg_done_c, 5);
        check("cont_mem_written", mem[10'h020], 32'h0BADF00D);
        tick();

        check("gnt_never_overlap", overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
